// File: rtl/fetch_buffer.sv
// fetch_buffer: consumer end of the fetch-unit PC interface.
//
// Issues one synchronous instruction-memory read per cycle while a FIFO slot is
// guaranteed (credit = buffered entries + in-flight read). It buffers the returned
// {pc, instr} pairs and presents them to decode with a valid/ready handshake. A
// redirect flushes both the buffered entries and the in-flight read.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   pc_i           current PC from the fetch unit
//   en_pc_o        advance request to the fetch unit (pc+1 next cycle)
//   redirect_i     same-cycle copy of the fetch unit's en_new_pc; flush request
//   imem_req_o     instruction memory read strobe
//   imem_addr_o    read address (equal to pc_i)
//   imem_rdata_i   read data, valid one cycle after imem_req_o
//   instr_valid_o  FIFO head is valid
//   instr_o        FIFO head instruction
//   instr_pc_o     PC of the FIFO head
//   instr_ready_i  decode accepts the head
module fetch_buffer #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned DEPTH   = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic               en_pc_o,
  input  logic               redirect_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               instr_valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  instr_pc_o,
  input  logic               instr_ready_i
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned PtrW = IdxW + 1;

  typedef logic [PtrW-1:0] ptr_t;

  localparam ptr_t DepthP = ptr_t'(DEPTH);
  localparam ptr_t OneP   = ptr_t'(1);

  // Storage: no reset needed, entries are only read when count_q != 0.
  logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];

  ptr_t              wr_ptr_q, wr_ptr_d;
  ptr_t              rd_ptr_q, rd_ptr_d;
  ptr_t              count_q, count_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;

  ptr_t credit;
  logic issue;
  logic push;
  logic pop;
  logic valid;

  // Credit counts the in-flight read so a response always has a slot to land in.
  // It uses the registered count, so a pop only reopens issue on the next cycle.
  always_comb begin
    credit = count_q + ptr_t'(inflight_q);
    issue  = rst_ni & ~redirect_i & (credit < DepthP);
    push   = inflight_q & ~redirect_i;
    valid  = (count_q != '0) & ~redirect_i;
    pop    = valid & instr_ready_i;
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    inflight_d    = issue;
    inflight_pc_d = issue ? pc_i : inflight_pc_q;

    if (redirect_i) begin
      // Flush wins over any push/pop seen this cycle.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + OneP;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + OneP;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + OneP;
        2'b01:   count_d = count_q - OneP;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem_q[wr_ptr_q[IdxW-1:0]]    <= inflight_pc_q;
      instr_mem_q[wr_ptr_q[IdxW-1:0]] <= imem_rdata_i;
    end
  end

  always_comb begin
    en_pc_o       = issue;
    imem_req_o    = issue;
    imem_addr_o   = pc_i;
    instr_valid_o = valid;
    instr_o       = instr_mem_q[rd_ptr_q[IdxW-1:0]];
    instr_pc_o    = pc_mem_q[rd_ptr_q[IdxW-1:0]];
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: fetch-unit and memory models drive the DUT,
// a queue-based reference predicts the outputs every cycle.
module tb_fetch_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic [11:0] pc;
  logic        en_pc;
  logic        redirect;
  logic [11:0] new_pc;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [11:0] instr_pc;
  logic        instr_ready;

  int n_pass  = 0;
  int n_total = 0;

  // Reference state: PCs buffered in order, plus the one outstanding read.
  logic [11:0] m_q[$];
  bit          m_infl    = 1'b0;
  logic [11:0] m_infl_pc = '0;
  int          rst_pulses = 0;
  int          seen_pulses = 0;
  logic        async_obs = 1'b0;

  fetch_buffer #(
    .ADDR_W (12),
    .INSTR_W(32),
    .DEPTH  (DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .pc_i         (pc),
    .en_pc_o      (en_pc),
    .redirect_i   (redirect),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_rdata_i (imem_rdata),
    .instr_valid_o(instr_valid),
    .instr_o      (instr),
    .instr_pc_o   (instr_pc),
    .instr_ready_i(instr_ready)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [11:0] a);
    return 32'h1000 + {20'h0, a};
  endfunction

  // Fetch unit: loads new_pc on redirect, otherwise advances on en_pc.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)        pc <= '0;
    else if (redirect) pc <= new_pc;
    else if (en_pc)    pc <= pc + 12'd1;
  end

  // Synchronous instruction memory, one-cycle latency.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem_word(imem_addr);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Called at each falling edge: compare DUT to the reference, then advance the
  // reference to what the coming rising edge must produce.
  task automatic model_check();
    bit exp_issue;
    bit exp_valid;
    if (rst_pulses != seen_pulses) begin
      chk("async_valid_drop", {31'b0, async_obs}, 32'd0);
      m_q.delete();
      m_infl      = 1'b0;
      seen_pulses = rst_pulses;
    end
    if (!rst_n) begin
      exp_issue = 1'b0;
      exp_valid = 1'b0;
    end else begin
      exp_issue = !redirect && ((m_q.size() + int'(m_infl)) < DEPTH);
      exp_valid = !redirect && (m_q.size() != 0);
    end
    chk("en_pc", {31'b0, en_pc}, {31'b0, exp_issue});
    chk("imem_req", {31'b0, imem_req}, {31'b0, exp_issue});
    if (exp_issue) chk("imem_addr", {20'b0, imem_addr}, {20'b0, pc});
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, exp_valid});
    if (exp_valid) begin
      chk("instr_pc", {20'b0, instr_pc}, {20'b0, m_q[0]});
      chk("instr", instr, mem_word(m_q[0]));
    end
    if (!rst_n || redirect) begin
      m_q.delete();
      m_infl = 1'b0;
    end else begin
      if (exp_valid && instr_ready) void'(m_q.pop_front());
      if (m_infl) m_q.push_back(m_infl_pc);
      m_infl    = exp_issue;
      m_infl_pc = pc;
    end
  endtask

  task automatic step(input logic rst, input logic rdy, input logic redir,
                      input logic [11:0] npc);
    @(posedge clk);
    #2;
    rst_n       = rst;
    instr_ready = rdy;
    redirect    = redir;
    new_pc      = npc;
    @(negedge clk);
    model_check();
  endtask

  // Asynchronous reset pulse strictly between two clock edges.
  task automatic pulse_reset(input logic rdy);
    @(posedge clk);
    #2;
    redirect = 1'b0;
    rst_n    = 1'b0;
    #2;
    async_obs = instr_valid;
    rst_pulses++;
    #2;
    rst_n       = 1'b1;
    instr_ready = rdy;
    @(negedge clk);
    model_check();
  endtask

  initial begin
    rst_n       = 1'b0;
    instr_ready = 1'b1;
    redirect    = 1'b0;
    new_pc      = '0;

    // Reset held three cycles, then release with pc=0.
    repeat (3) step(1'b0, 1'b1, 1'b0, 12'h0);
    step(1'b1, 1'b1, 1'b0, 12'h0);
    chk("rel_req", {31'b0, imem_req}, 32'd1);
    chk("rel_addr", {20'b0, imem_addr}, 32'd0);

    // Streaming: first instruction visible two cycles after release.
    step(1'b1, 1'b1, 1'b0, 12'h0);
    chk("stream_c1_valid", {31'b0, instr_valid}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 12'h0);
    chk("stream_c2_valid", {31'b0, instr_valid}, 32'd1);
    chk("stream_c2_pc", {20'b0, instr_pc}, 32'd0);
    chk("stream_c2_instr", instr, 32'h1000);
    for (int k = 3; k <= 12; k++) step(1'b1, 1'b1, 1'b0, 12'h0);
    chk("stream_c12_pc", {20'b0, instr_pc}, 32'd10);
    chk("stream_c12_instr", instr, 32'h100A);

    // Redirect to 0x100 during streaming.
    step(1'b1, 1'b1, 1'b1, 12'h100);
    chk("redir_valid", {31'b0, instr_valid}, 32'd0);
    chk("redir_en_pc", {31'b0, en_pc}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 12'h0);
    chk("redir_issue_addr", {20'b0, imem_addr}, 32'h100);
    chk("redir_issue", {31'b0, imem_req}, 32'd1);
    step(1'b1, 1'b1, 1'b0, 12'h0);
    step(1'b1, 1'b1, 1'b0, 12'h0);
    chk("redir_first_pc", {20'b0, instr_pc}, 32'h100);
    repeat (4) step(1'b1, 1'b1, 1'b0, 12'h0);

    // Backpressure from release: fills after pc 0..3.
    step(1'b0, 1'b0, 1'b0, 12'h0);
    step(1'b1, 1'b0, 1'b0, 12'h0);
    repeat (5) step(1'b1, 1'b0, 1'b0, 12'h0);
    chk("full_en_pc", {31'b0, en_pc}, 32'd0);
    chk("full_pc_held", {20'b0, pc}, 32'd4);
    step(1'b1, 1'b1, 1'b0, 12'h0);
    chk("full_pop_pc", {20'b0, instr_pc}, 32'd0);
    chk("full_pop_no_issue", {31'b0, en_pc}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 12'h0);
    chk("reopen_issue", {31'b0, en_pc}, 32'd1);
    chk("reopen_addr", {20'b0, imem_addr}, 32'd4);
    // Push of pc4 and pop of pc1 in the same cycle.
    step(1'b1, 1'b1, 1'b0, 12'h0);
    chk("pushpop_pc", {20'b0, instr_pc}, 32'd1);
    // Redirect coinciding with ready: no handshake, empty afterwards.
    step(1'b1, 1'b1, 1'b1, 12'h200);
    chk("redir_rdy_valid", {31'b0, instr_valid}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 12'h0);
    chk("redir_rdy_empty", {31'b0, instr_valid}, 32'd0);
    chk("redir_rdy_addr", {20'b0, imem_addr}, 32'h200);

    // Reset mid-operation with three entries buffered.
    step(1'b0, 1'b0, 1'b0, 12'h0);
    step(1'b1, 1'b0, 1'b0, 12'h0);
    repeat (3) step(1'b1, 1'b0, 1'b0, 12'h0);
    chk("pre_pulse_valid", {31'b0, instr_valid}, 32'd1);
    pulse_reset(1'b1);
    chk("post_pulse_addr", {20'b0, imem_addr}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 12'h0);
    step(1'b1, 1'b1, 1'b0, 12'h0);
    chk("post_pulse_pc", {20'b0, instr_pc}, 32'd0);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        pulse_reset(1'($urandom_range(0, 1)));
      end else begin
        step(1'b1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
             12'($urandom_range(0, 4095)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
